// File: rtl/cnt_link_pkg.sv
// Purpose: shared types and constants for the counter-bus link checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cnt_link_pkg;

    localparam int BUS_W          = 8;
    localparam int DEF_LOCK_COUNT = 16;
    localparam int DEF_LOSS_COUNT = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } link_state_t;

endpackage

// File: rtl/sat_counter.sv
// Purpose: W-bit up counter that sticks at all-ones instead of wrapping.
// Latency: count updates on the edge after inc is sampled high.
// Backpressure: none; inc is accepted every cycle.
//
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset, clears the count
//   inc     - increment enable
//   cnt     - current count (registered)
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_link_checker.sv
// Purpose: checks that the 8-bit generator bus increments by 1 (mod 256) every clock; tracks lock.
// Latency: a bus value sampled at edge k is compared at edge k+1; state/err/err_cnt change then.
// Backpressure: none; the bus is free-running and sampled every clock.
//
// Ports:
//   clk     - generator's forwarded clock, rising edge
//   reset_n - asynchronous active-low reset
//   b1      - counter bus from the generator
//   locked  - 1 while in LOCKED (registered)
//   err     - mismatch indicator while LOCKED (registered)
//   err_cnt - saturating count of LOCKED mismatches (registered)
//   LED     - status LED, same as locked
//
// Build option CNT_CHECK_STICKY_EN: when defined, err latches on the first
// LOCKED mismatch and only reset clears it; otherwise err is a one-cycle
// pulse per LOCKED mismatch.
module counter_link_checker
    import cnt_link_pkg::*;
#(
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int LOSS_COUNT = DEF_LOSS_COUNT,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       b1,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             LED
);

    localparam logic [7:0] LOCK_C = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_C = 8'(LOSS_COUNT);

    // Sampler
    logic [BUS_W-1:0] rx_q;
    logic [BUS_W-1:0] prev_q;
    logic             rx_full;   // rx_q holds a real bus sample (not the reset value)
    logic             have_prev; // prev_q holds a real bus sample too

    // Compare / FSM
    link_state_t      state_q, state_d;
    logic [7:0]       run_q, run_d;
    logic [7:0]       bad_q, bad_d;
    logic             err_q, err_d;
    logic             mis;
    logic             ok;
    logic [BUS_W-1:0] exp_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_q      <= '0;
            prev_q    <= '0;
            rx_full   <= 1'b0;
            have_prev <= 1'b0;
        end else begin
            rx_q      <= b1;
            prev_q    <= rx_q;
            rx_full   <= 1'b1;
            have_prev <= rx_full;
        end
    end

    // 8-bit sum wraps, so 0xFF followed by 0x00 counts as a good increment.
    assign exp_val = prev_q + 8'd1;
    assign ok      = have_prev & (rx_q == exp_val);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HUNT;
            run_q   <= '0;
            bad_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        bad_d   = bad_q;
        mis     = 1'b0;
        // Nothing to compare until two real samples are in the pipe.
        if (have_prev) begin
            case (state_q)
                HUNT: begin
                    if (ok) begin
                        if (run_q + 8'd1 == LOCK_C) begin
                            state_d = LOCKED;
                            run_d   = '0;
                            bad_d   = '0;
                        end else begin
                            run_d = run_q + 8'd1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    if (ok) begin
                        bad_d = '0;
                    end else begin
                        // The mismatch is counted even on the edge that drops lock.
                        mis = 1'b1;
                        if (bad_q + 8'd1 == LOSS_C) begin
                            state_d = HUNT;
                            run_d   = '0;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

`ifdef CNT_CHECK_STICKY_EN
    assign err_d = err_q | mis;
`else
    assign err_d = mis;
`endif

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (mis),
        .cnt     (err_cnt)
    );

    assign locked = (state_q == LOCKED);
    assign LED    = (state_q == LOCKED);
    assign err    = err_q;

endmodule
